// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use, taken branch, multi-cycle dmem with timeout.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        ex_mem_en,
    output logic        mem_wb_flush,
    output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ABORT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          mem_err_nxt;
    logic          mem_access, mem_stall, load_use;
    logic          br_apply, lu_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    always_comb begin
        mem_access = mem_mem_read | mem_mem_write;
        // Reset abandons any access in flight in the same cycle
        dmem_req   = mem_access & (state != MEM_ABORT) & ~reset;
        mem_stall  = dmem_req & ~dmem_ack;
        load_use   = ex_mem_read & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
        br_apply   = ~reset & ~mem_stall & ex_branch_taken;
        lu_stall   = ~reset & ~mem_stall & ~ex_branch_taken & load_use;

        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;

        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else begin
            if (br_apply) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu_stall) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
            // Squash the result of the access that just timed out
            if (state == MEM_ABORT) mem_wb_flush = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == TO_CNT) begin
                    state_nxt    = MEM_ABORT;
                    wait_cnt_nxt = '0;
                    mem_err_nxt  = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            MEM_ABORT: state_nxt = RUN;
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mem_stall | lu_stall) stall_cnt <= stall_cnt + 32'd1;
            if (br_apply)             flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected outputs, negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic        mem_mem_read = 1'b0, mem_mem_write = 1'b0, dmem_ack = 1'b0;
    logic        dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, mem_wb_flush, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_flush(mem_wb_flush), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

`ifndef HAZARD_PERF_CNT_EN
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
    localparam logic [6:0] C_NORM = 7'b1101010;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_BR   = 7'b1111110;
    localparam logic [6:0] C_MS   = 7'b0000001;
    localparam logic [6:0] C_RST  = 7'b0010101;
    localparam logic [6:0] C_AB   = 7'b1101011;

    typedef struct {
        logic [8:0]  ctl;   // {dmem_req, C_*, mem_err}
        logic [31:0] sc;
        logic [31:0] fc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0;

    task automatic cyc(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u2, input logic emr, input logic [4:0] rd, input logic br,
                       input logic mr, input logic mw, input logic ack,
                       input logic e_req, input logic [6:0] e_ctl, input logic e_err,
                       input int e_sc, input int e_fc, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
        ex_mem_read = emr; ex_rd = rd; ex_branch_taken = br;
        mem_mem_read = mr; mem_mem_write = mw; dmem_ack = ack;
        e.ctl = {e_req, e_ctl, e_err};
        e.sc = 32'(e_sc);
        e.fc = 32'(e_fc);
        e.name = nm;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e = exp_q.pop_front();
            act = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                   ex_mem_en, mem_wb_flush, mem_err};
            n_chk++;
            if (act === e.ctl) n_pass++;
            else $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
`ifdef HAZARD_PERF_CNT_EN
            n_chk++;
            if (stall_cnt === e.sc && flush_cnt === e.fc) n_pass++;
            else $display("FAIL %s perf: got sc=%0d fc=%0d want sc=%0d fc=%0d",
                          e.name, stall_cnt, flush_cnt, e.sc, e.fc);
`endif
        end
    end

    initial begin
        //   rst rs1 rs2 u2 emr rd br mr mw ack | req ctl err sc fc
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_RST,  0, 0, 0, "reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 0, 0, 0, "idle");
        cyc(0, 5, 0, 0, 1, 5, 0, 0, 0, 0,  0, C_LU,   0, 0, 0, "lu_rs1");
        cyc(0, 5, 0, 0, 0, 5, 0, 0, 0, 0,  0, C_NORM, 0, 1, 0, "lu_after");
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, C_NORM, 0, 1, 0, "rd_x0");
        cyc(0, 3, 7, 1, 1, 7, 0, 0, 0, 0,  0, C_LU,   0, 1, 0, "lu_rs2");
        cyc(0, 3, 7, 0, 1, 7, 0, 0, 0, 0,  0, C_NORM, 0, 2, 0, "rs2_unused");
        cyc(0, 5, 0, 0, 1, 5, 1, 0, 0, 0,  0, C_BR,   0, 2, 0, "br_over_lu");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 0, 2, 1, "br_after");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_MS,   0, 2, 1, "wait1");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_MS,   0, 3, 1, "wait2");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_MS,   0, 4, 1, "wait3");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, C_NORM, 0, 5, 1, "ack");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 0, 5, 1, "post_ack");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, C_NORM, 0, 5, 1, "zero_wait");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 0, 5, 1, "post_zw");
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  1, C_MS,   0, 5, 1, "br_in_stall");
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 1,  1, C_BR,   0, 6, 1, "br_release");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 0, 6, 2, "post_br");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_MS,   0, 6, 2, "to_c0");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_MS,   0, 7, 2, "to_c1");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_MS,   0, 8, 2, "to_c2");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_MS,   0, 9, 2, "to_c3");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_MS,   0, 10, 2, "to_c4");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, C_AB,   1, 11, 2, "abort");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 1, 11, 2, "post_abort");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_MS,   1, 11, 2, "wait_again");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, C_RST,  1, 12, 2, "reset_mid_wait");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 0, 0, 0, "post_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, C_MS,   0, 0, 0, "run_after_rst");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, C_NORM, 0, 1, 0, "ack_after_rst");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, C_NORM, 0, 1, 0, "final");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RV32I core. It consumes the hazard-relevant fields of the IF/ID, ID/EX and EX/MEM pipeline registers and drives the enable and flush controls back into those registers. It resolves three hazards: load-use hazards, taken branches and jumps, and wait states from multi-cycle data memory. It includes a data-memory request/acknowledge handshake with a timeout watchdog.

## Interface
- MEM_TIMEOUT, 255, max consecutive un-acked dmem_req cycles before abort (>=1)

- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- id_rs1  in  5  IF/ID instr[19:15]
- id_rs2  in  5  IF/ID instr[24:20]
- id_uses_rs2  in  1  ID instruction reads rs2 (R/S/B type)
- ex_mem_read  in  1  ID/EX MemRead
- ex_rd  in  5  ID/EX rd
- ex_branch_taken  in  1  EX resolved taken branch/JAL/JALR
- mem_mem_read  in  1  EX/MEM MemRead
- mem_mem_write  in  1  EX/MEM MemWrite
- dmem_ack  in  1  data memory completes access this cycle
- dmem_req  out  1  data memory access pending
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID load NOP
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX load bubble (all control bits 0)
- ex_mem_en  out  1  EX/MEM load enable
- mem_wb_flush  out  1  MEM/WB load bubble (RegWrite=0)
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  32  stall cycles (HAZARD_PERF_CNT_EN only)
- flush_cnt  out  32  branch flush events (HAZARD_PERF_CNT_EN only)

## Operation
- FSM states: RUN, MEM_WAIT, MEM_ABORT. Registered: state, wait counter (width $clog2(MEM_TIMEOUT+1)), mem_err, perf counters. All control outputs are combinational from state and inputs.
- mem_access = mem_mem_read | mem_mem_write.
- dmem_req = mem_access while state is RUN or MEM_WAIT. It is 0 in MEM_ABORT.
- mem_stall = dmem_req & ~dmem_ack.
  - pc_en, if_id_en, id_ex_en and ex_mem_en are all 0.
  - mem_wb_flush = 1.
  - All other flushes are 0.
- load_use = ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | (id_uses_rs2 & ex_rd == id_rs2)).
- Priority: reset > mem_stall > ex_branch_taken > load_use > normal.
- Branch, when no mem_stall:
  - if_id_flush = 1 and id_ex_flush = 1.
  - All enables are 1.
  - Load-use is ignored, because the dependent instruction is squashed.
- Load-use, when no mem_stall and no branch:
  - pc_en = 0 and if_id_en = 0.
  - id_ex_flush = 1.
  - ex_mem_en = 1 and id_ex_en = 1.
- Normal: all enables are 1 and all flushes are 0.
- Transitions:
  - RUN -> MEM_WAIT on mem_stall. The wait counter is loaded with 1.
  - MEM_WAIT -> RUN on dmem_ack. The counter is cleared.
  - MEM_WAIT, no ack, counter == MEM_TIMEOUT -> MEM_ABORT. mem_err is set.
  - MEM_WAIT, otherwise: the counter increments.
  - MEM_ABORT lasts exactly one cycle, then goes to RUN.
    - dmem_req = 0.
    - All enables are 1.
    - mem_wb_flush = 1 (squashes the failed load/store result).
    - Branch and load-use rules apply normally.
- A branch or load-use condition present during a stall is held by the frozen ID/EX. It takes effect in the release cycle.
- mem_err clears only on reset.

## Timing
- Reset (cycle with reset=1):
  - Outputs: pc_en, if_id_en, id_ex_en, ex_mem_en and dmem_req are all 0; if_id_flush, id_ex_flush and mem_wb_flush are all 1.
  - Registered values: state = RUN, wait counter = 0, mem_err = 0, stall_cnt = 0, flush_cnt = 0.
  - Reset mid-wait abandons the access; dmem_req drops in the same cycle.
- Zero-wait memory: dmem_ack in the same cycle as dmem_req causes no stall and no state change.
- An access acked after N cycles costs N stall cycles. dmem_req stays high through the ack cycle inclusive.
- Timeout: MEM_TIMEOUT+1 cycles of dmem_req=1, then 1 MEM_ABORT cycle with dmem_req=0. mem_err rises on the first MEM_ABORT cycle.
- Load-use costs exactly 1 bubble. Branch costs exactly 2 squashed instructions.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle with mem_stall or load_use stall.
  - flush_cnt increments on every cycle in which ex_branch_taken is applied.
  - Both counters wrap at 2^32.
- HAZARD_PERF_CNT_EN undefined: the stall_cnt and flush_cnt ports and their logic are absent. All other behaviour is identical.

## Test plan
- lw x5 in EX (ex_mem_read=1, ex_rd=5), id_rs1=5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle normal.
- ex_rd=0 with ex_mem_read=1, id_rs1=0 -> no stall.
- ex_branch_taken=1 together with load_use -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt +1, stall_cnt unchanged.
- mem_mem_read=1, dmem_ack after 3 cycles -> dmem_req high 4 cycles; all enables 0 and mem_wb_flush=1 for 3 cycles; then back to RUN; stall_cnt=3.
- MEM_TIMEOUT=4, no ack -> dmem_req high 5 cycles, then 1 cycle with dmem_req=0 and mem_wb_flush=1; mem_err=1 thereafter.
- reset asserted during MEM_WAIT -> same cycle dmem_req=0 and all flushes=1; after reset, state RUN and mem_err=0.
